ysyx_bus_arbiter_rr: RTL and testbench

- Parametrised N-master to one-AXI4-master bus arbiter. It succeeds the fixed two-client IFU/LSU arbiter.
- Clients (IFU, LSU, DMA, debug, ...) issue single-beat read/write requests. The block grants one client at a time, by round-robin or fixed priority.
- It drives the 64-bit AXI4 master port with the requester index on arid/awid, and steers 32-bit data across 64-bit lanes.
- It forwards rresp/bresp errors back to the requester instead of asserting on them, and aborts stalled transactions with a timeout.

---
 rtl/ysyx_bus_pkg.sv | 29 ++
 rtl/ysyx_bus_arbiter_rr_pick.sv | 40 ++++
 rtl/ysyx_bus_arbiter_rr.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ysyx_bus_arbiter_rr.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_bus_pkg.sv
// Shared types and constants for the N-client to AXI4 bus arbiter.
// Holds the FSM state encoding, the AXI burst/response codes and the strobe-to-size mapping.
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    B    = 3'd4
  } state_e;

  localparam int         AXI_DATA_W     = 64;
  localparam int         AXI_ID_W       = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Clients only ever issue byte, half-word or word strobes.
  function automatic logic [2:0] strb_to_size(input logic [3:0] strb);
    logic [2:0] size;
    case (strb)
      4'h1:    size = 3'd0;
      4'h3:    size = 3'd1;
      default: size = 3'd2;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ysyx_bus_arbiter_rr_pick.sv
// Combinational request picker: round-robin from a pointer, or fixed lowest-index priority.
// Outputs both a one-hot grant and its binary index.
module ysyx_rr_pick #(
  parameter int NMST  = 2,
  parameter int RR_EN = 1,
  parameter int IW    = (NMST > 1) ? $clog2(NMST) : 1
) (
  input  logic [NMST-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NMST-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [NMST-1:0] w_mask;
  logic [NMST-1:0] w_hi;
  logic [NMST-1:0] w_cand;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NMST; i++) begin
      w_mask[i] = (RR_EN != 0) && (i >= int'(i_ptr));
    end
  end

  assign w_hi   = i_req & w_mask;
  assign w_cand = (|w_hi) ? w_hi : i_req;

  always_comb begin
    o_idx = '0;
    for (int i = NMST - 1; i >= 0; i--) begin
      if (w_cand[i]) o_idx = IW'(i);
    end
  end

  assign o_any   = |i_req;
  assign o_grant = o_any ? (NMST'(1) << o_idx) : '0;

endmodule

// File: rtl/ysyx_bus_arbiter_rr.sv
// N-client single-beat request arbiter driving one 64-bit AXI4 master port.
// One transaction in flight; errors and timeouts are reported to the requester via c_err.
module ysyx_bus_arbiter_rr
  import ysyx_bus_pkg::*;
#(
  parameter int NMST   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1,
  parameter int TMO_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NMST-1:0]        c_valid,
  input  logic [NMST-1:0]        c_write,
  input  logic [NMST*ADDR_W-1:0] c_addr,
  input  logic [NMST*DATA_W-1:0] c_wdata,
  input  logic [NMST*4-1:0]      c_strb,
  output logic [DATA_W-1:0]      c_rdata,
  output logic [NMST-1:0]        c_done,
  output logic [NMST-1:0]        c_err,
  output logic                   io_master_arvalid,
  input  logic                   io_master_arready,
  output logic [AXI_ID_W-1:0]    io_master_arid,
  output logic [ADDR_W-1:0]      io_master_araddr,
  output logic [7:0]             io_master_arlen,
  output logic [2:0]             io_master_arsize,
  output logic [1:0]             io_master_arburst,
  input  logic                   io_master_rvalid,
  output logic                   io_master_rready,
  input  logic [AXI_ID_W-1:0]    io_master_rid,
  input  logic [AXI_DATA_W-1:0]  io_master_rdata,
  input  logic [1:0]             io_master_rresp,
  input  logic                   io_master_rlast,
  output logic                   io_master_awvalid,
  input  logic                   io_master_awready,
  output logic [AXI_ID_W-1:0]    io_master_awid,
  output logic [ADDR_W-1:0]      io_master_awaddr,
  output logic [7:0]             io_master_awlen,
  output logic [2:0]             io_master_awsize,
  output logic [1:0]             io_master_awburst,
  output logic                   io_master_wvalid,
  input  logic                   io_master_wready,
  output logic [AXI_DATA_W-1:0]  io_master_wdata,
  output logic [7:0]             io_master_wstrb,
  output logic                   io_master_wlast,
  input  logic                   io_master_bvalid,
  output logic                   io_master_bready,
  input  logic [AXI_ID_W-1:0]    io_master_bid,
  input  logic [1:0]             io_master_bresp,
  output state_e                 o_dbg_state
);

  localparam int            IW       = (NMST > 1) ? $clog2(NMST) : 1;
  localparam int            CW       = (TMO_W > 0) ? TMO_W : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((1 << CW) - 2);

  state_e              r_state;
  logic [IW-1:0]       r_grant;
  logic [IW-1:0]       r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_strb;
  logic [CW-1:0]       r_tmo;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_aw_ok;
  logic                r_w_ok;
  logic [NMST-1:0]     r_done;
  logic [NMST-1:0]     r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [NMST-1:0]     w_pick_oh;
  logic [IW-1:0]       w_pick_idx;
  logic                w_any;
  logic                w_pick_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [3:0]          w_sel_strb;
  logic [NMST-1:0]     w_grant_oh;
  logic [IW-1:0]       w_ptr_nxt;
  logic [AXI_ID_W-1:0] w_id;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_done;
  logic                w_w_done;
  logic                w_step;
  logic                w_tmo_fire;
  logic                w_abort;
  logic [DATA_W-1:0]   w_wshift;
  logic [3:0]          w_sstrb;
  logic                w_unused;

  ysyx_rr_pick #(
    .NMST  (NMST),
    .RR_EN (RR_EN),
    .IW    (IW)
  ) u_pick (
    .i_req   (c_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_any   (w_any)
  );

  assign w_pick_wr   = |(c_write & w_pick_oh);
  assign w_sel_addr  = c_addr[w_pick_idx*ADDR_W +: ADDR_W];
  assign w_sel_wdata = c_wdata[w_pick_idx*DATA_W +: DATA_W];
  assign w_sel_strb  = c_strb[w_pick_idx*4 +: 4];

  assign w_grant_oh = NMST'(1) << r_grant;
  assign w_ptr_nxt  = (r_grant == IW'(NMST - 1)) ? '0 : r_grant + 1'b1;
  assign w_id       = AXI_ID_W'(r_grant);

  assign w_aw_hs   = r_awvalid & io_master_awready;
  assign w_w_hs    = r_wvalid & io_master_wready;
  assign w_aw_done = r_aw_ok | w_aw_hs;
  assign w_w_done  = r_w_ok | w_w_hs;

  // A handshake in the same cycle as the timeout wins over the abort.
  always_comb begin
    w_step = 1'b1;
    case (r_state)
      AR:      w_step = io_master_arready;
      R:       w_step = io_master_rvalid;
      AW:      w_step = w_aw_done & w_w_done;
      B:       w_step = io_master_bvalid;
      default: w_step = 1'b1;
    endcase
  end

  assign w_tmo_fire = (TMO_W > 0) && (r_tmo == TMO_LAST);
  assign w_abort    = w_tmo_fire & ~w_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_tmo     <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_ok   <= 1'b0;
      r_w_ok    <= 1'b0;
      r_done    <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      if (r_state != IDLE && r_tmo != '1) r_tmo <= r_tmo + 1'b1;

      case (r_state)
        IDLE: begin
          // Ready stays high here so a late beat after a timeout is drained.
          r_rready <= 1'b1;
          r_bready <= 1'b1;
          r_tmo    <= '0;
          // The completing client still holds c_valid during its c_done cycle.
          if (w_any && (r_done == '0)) begin
            r_grant  <= w_pick_idx;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_strb   <= w_sel_strb;
            r_rready <= 1'b0;
            r_bready <= 1'b0;
            if (w_pick_wr) begin
              r_state   <= AW;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_ok   <= 1'b0;
              r_w_ok    <= 1'b0;
            end else begin
              r_state   <= AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        AR: begin
          if (io_master_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
            r_tmo     <= '0;
          end
        end
        R: begin
          if (io_master_rvalid) begin
            r_rdata  <= r_addr[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
            r_done   <= w_grant_oh;
            r_err    <= ((io_master_rresp != AXI_RESP_OKAY) || (io_master_rid != w_id)) ?
                        w_grant_oh : '0;
            r_ptr    <= w_ptr_nxt;
            r_bready <= 1'b1;
            r_state  <= IDLE;
            r_tmo    <= '0;
          end
        end
        AW: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_ok   <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_ok   <= 1'b1;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= B;
            r_tmo    <= '0;
          end
        end
        B: begin
          if (io_master_bvalid) begin
            r_done   <= w_grant_oh;
            r_err    <= (io_master_bresp != AXI_RESP_OKAY) ? w_grant_oh : '0;
            r_ptr    <= w_ptr_nxt;
            r_rready <= 1'b1;
            r_state  <= IDLE;
            r_tmo    <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_abort) begin
        r_state   <= IDLE;
        r_arvalid <= 1'b0;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_rready  <= 1'b1;
        r_bready  <= 1'b1;
        r_done    <= w_grant_oh;
        r_err     <= w_grant_oh;
        r_ptr     <= w_ptr_nxt;
        r_tmo     <= '0;
      end
    end
  end

  // 32-bit store data is shifted into its byte lanes and mirrored on both halves.
  assign w_wshift = r_wdata << {r_addr[1:0], 3'b000};
  assign w_sstrb  = r_strb << r_addr[1:0];

  assign io_master_arvalid = r_arvalid;
  assign io_master_arid    = w_id;
  assign io_master_araddr  = r_addr;
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = strb_to_size(r_strb);
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_rready  = r_rready;

  assign io_master_awvalid = r_awvalid;
  assign io_master_awid    = w_id;
  assign io_master_awaddr  = r_addr;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = strb_to_size(r_strb);
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_wvalid  = r_wvalid;
  assign io_master_wdata   = {w_wshift, w_wshift};
  assign io_master_wstrb   = r_addr[2] ? {w_sstrb, 4'b0000} : {4'b0000, w_sstrb};
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = r_bready;

  assign c_rdata     = r_rdata;
  assign c_done      = r_done;
  assign c_err       = r_err;
  assign o_dbg_state = r_state;

  assign w_unused = ^{io_master_rlast, io_master_bid};

endmodule

// File: tb/tb_ysyx_bus_arbiter_rr.sv
// Directed bench for the round-robin bus arbiter: a 4-client RR instance with a short
// timeout driven step by step, plus a fixed-priority instance with an always-ready slave.
module tb_ysyx_bus_arbiter_rr;
  import ysyx_bus_pkg::*;

  localparam int NM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- RR instance signals ----------------
  logic [NM-1:0]    c_valid, c_write;
  logic [NM*32-1:0] c_addr, c_wdata;
  logic [NM*4-1:0]  c_strb;
  logic [31:0]      c_rdata;
  logic [NM-1:0]    c_done, c_err;
  logic             arvalid, arready, rvalid, rready, rlast;
  logic             awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]       arid, rid, awid, bid;
  logic [31:0]      araddr, awaddr;
  logic [7:0]       arlen, awlen, wstrb;
  logic [2:0]       arsize, awsize;
  logic [1:0]       arburst, awburst, rresp, bresp;
  logic [63:0]      rdata, wdata;
  state_e           dbg_state;

  // ---------------- fixed-priority instance signals ----------------
  logic [NM-1:0]    f_c_valid;
  logic [31:0]      f_c_rdata;
  logic [NM-1:0]    f_c_done, f_c_err;
  logic             f_arvalid, f_rready, f_awvalid, f_wvalid, f_wlast, f_bready;
  logic [3:0]       f_arid, f_awid;
  logic [31:0]      f_araddr, f_awaddr;
  logic [7:0]       f_arlen, f_awlen, f_wstrb;
  logic [2:0]       f_arsize, f_awsize;
  logic [1:0]       f_arburst, f_awburst;
  logic [63:0]      f_wdata;
  state_e           f_dbg_state;

  ysyx_bus_arbiter_rr #(.NMST(NM), .ADDR_W(32), .DATA_W(32), .RR_EN(1), .TMO_W(4)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata), .c_strb(c_strb),
    .c_rdata(c_rdata), .c_done(c_done), .c_err(c_err),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_arid(arid),
    .io_master_araddr(araddr), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rid(rid),
    .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awid(awid),
    .io_master_awaddr(awaddr), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bid(bid),
    .io_master_bresp(bresp),
    .o_dbg_state(dbg_state)
  );

  ysyx_bus_arbiter_rr #(.NMST(NM), .ADDR_W(32), .DATA_W(32), .RR_EN(0), .TMO_W(8)) dut_fix (
    .clk(clk), .rst(rst),
    .c_valid(f_c_valid), .c_write(4'b0000), .c_addr({4{32'h2000_0000}}),
    .c_wdata({4{32'h0}}), .c_strb({4{4'hf}}),
    .c_rdata(f_c_rdata), .c_done(f_c_done), .c_err(f_c_err),
    .io_master_arvalid(f_arvalid), .io_master_arready(1'b1), .io_master_arid(f_arid),
    .io_master_araddr(f_araddr), .io_master_arlen(f_arlen), .io_master_arsize(f_arsize),
    .io_master_arburst(f_arburst),
    .io_master_rvalid(1'b1), .io_master_rready(f_rready), .io_master_rid(4'h0),
    .io_master_rdata(64'h0), .io_master_rresp(2'b00), .io_master_rlast(1'b1),
    .io_master_awvalid(f_awvalid), .io_master_awready(1'b1), .io_master_awid(f_awid),
    .io_master_awaddr(f_awaddr), .io_master_awlen(f_awlen), .io_master_awsize(f_awsize),
    .io_master_awburst(f_awburst),
    .io_master_wvalid(f_wvalid), .io_master_wready(1'b1), .io_master_wdata(f_wdata),
    .io_master_wstrb(f_wstrb), .io_master_wlast(f_wlast),
    .io_master_bvalid(1'b1), .io_master_bready(f_bready), .io_master_bid(4'h0),
    .io_master_bresp(2'b00),
    .o_dbg_state(f_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  cap_id;
  logic [31:0] cap_addr;
  logic [2:0]  cap_size;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb;
  logic        cap_wlast;
  int          cap_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_client(input int i, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] strb);
    c_write[i]          = wr;
    c_addr[i*32 +: 32]  = addr;
    c_wdata[i*32 +: 32] = wd;
    c_strb[i*4 +: 4]    = strb;
  endtask

  task automatic wait_valid(input logic is_wr);
    cap_lat = 0;
    while (((is_wr ? awvalid : arvalid) !== 1'b1) && cap_lat < 30) begin
      @(negedge clk);
      cap_lat++;
    end
    check("addr_valid_seen", 64'(cap_lat < 30), 64'd1);
    cap_id    = is_wr ? awid : arid;
    cap_addr  = is_wr ? awaddr : araddr;
    cap_size  = is_wr ? awsize : arsize;
    cap_wdata = wdata;
    cap_wstrb = wstrb;
    cap_wlast = wlast;
  endtask

  task automatic do_read(input logic [63:0] data, input logic [1:0] resp, input logic bad_id);
    wait_valid(1'b0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("rready_in_r", 64'(rready), 64'd1);
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    rid    = bad_id ? (cap_id ^ 4'h1) : cap_id;
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic do_write(input logic split);
    wait_valid(1'b1);
    if (!split) begin
      awready = 1'b1;
      wready  = 1'b1;
      @(negedge clk);
      awready = 1'b0;
      wready  = 1'b0;
    end else begin
      awready = 1'b0;
      wready  = 1'b1;
      @(negedge clk);
      check("split_wvalid_drop", 64'(wvalid), 64'd0);
      check("split_awvalid_hold", 64'(awvalid), 64'd1);
      check("split_no_done", 64'(c_done), 64'd0);
      wready  = 1'b0;
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
      check("split_awvalid_drop", 64'(awvalid), 64'd0);
    end
    check("bready_in_b", 64'(bready), 64'd1);
    bvalid = 1'b1;
    bresp  = 2'b00;
    bid    = cap_id;
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    c_valid = '0; c_write = '0; c_addr = '0; c_wdata = '0; c_strb = '0;
    f_c_valid = 4'b1111;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_done", 64'(c_done), 64'd0);
    check("rst_err", 64'(c_err), 64'd0);
    check("rst_rdata", 64'(c_rdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_rready", 64'(rready), 64'd1);
    check("idle_bready", 64'(bready), 64'd1);

    // Fixed priority: client 0 keeps winning while it keeps requesting
    begin
      int seen = 0;
      for (int k = 0; k < 40 && seen < 3; k++) begin
        @(negedge clk);
        if (f_arvalid) begin
          check("fixed_grant", 64'(f_arid), 64'd0);
          seen++;
        end
      end
      check("fixed_grant_count", 64'(seen), 64'd3);
    end

    // Two simultaneous loads, lanes from the upper then lower half
    set_client(0, 1'b0, 32'h8000_0004, 32'h0, 4'hf);
    set_client(1, 1'b0, 32'h8000_0010, 32'h0, 4'hf);
    c_valid = 4'b0011;
    do_read(64'h1111_2222_3333_4444, 2'b00, 1'b0);
    check("t1a_latency", 64'(cap_lat), 64'd1);
    check("t1a_arid", 64'(cap_id), 64'd0);
    check("t1a_araddr", 64'(cap_addr), 64'h8000_0004);
    check("t1a_arsize", 64'(cap_size), 64'd2);
    check("t1a_arlen", 64'(arlen), 64'd0);
    check("t1a_arburst", 64'(arburst), 64'(AXI_BURST_INCR));
    check("t1a_done", 64'(c_done), 64'b0001);
    check("t1a_err", 64'(c_err), 64'd0);
    check("t1a_rdata", 64'(c_rdata), 64'h1111_2222);
    c_valid[0] = 1'b0;
    do_read(64'h5555_6666_7777_8888, 2'b00, 1'b0);
    check("t1b_regrant_gap", 64'(cap_lat), 64'd2);
    check("t1b_arid", 64'(cap_id), 64'd1);
    check("t1b_araddr", 64'(cap_addr), 64'h8000_0010);
    check("t1b_done", 64'(c_done), 64'b0010);
    check("t1b_rdata", 64'(c_rdata), 64'h7777_8888);
    c_valid = '0;
    @(negedge clk);
    check("t1b_done_single", 64'(c_done), 64'd0);

    // Round-robin fairness from a fresh pointer, all four requesting continuously
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NM; i++) set_client(i, 1'b0, 32'h1000_0000 + 32'(i * 8), 32'h0, 4'hf);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd3); exp_q.push_back(4'd0);
    c_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_id;
      do_read(64'hCAFE_0000_0000_0000 + 64'(k), 2'b00, 1'b0);
      exp_id = exp_q.pop_front();
      check("rr_order", 64'(cap_id), 64'(exp_id));
      check("rr_done", 64'(c_done), 64'(4'b0001 << exp_id));
    end
    c_valid = '0;
    @(negedge clk);
    check("rr_no_grant_in_done", 64'(dbg_state), 64'(IDLE));

    // Byte store to the top byte lane
    set_client(2, 1'b1, 32'h8000_0007, 32'h0000_00AB, 4'h1);
    c_valid = 4'b0100;
    do_write(1'b0);
    check("bst_awid", 64'(cap_id), 64'd2);
    check("bst_awaddr", 64'(cap_addr), 64'h8000_0007);
    check("bst_awsize", 64'(cap_size), 64'd0);
    check("bst_wstrb", 64'(cap_wstrb), 64'h80);
    check("bst_wdata_top", 64'(cap_wdata[63:56]), 64'hAB);
    check("bst_wdata", cap_wdata, 64'hAB00_0000_AB00_0000);
    check("bst_wlast", 64'(cap_wlast), 64'd1);
    check("bst_done", 64'(c_done), 64'b0100);
    check("bst_err", 64'(c_err), 64'd0);
    c_valid = '0;

    // Half-word store with awready held off while wready is high
    set_client(3, 1'b1, 32'h8000_0002, 32'h0000_1234, 4'h3);
    c_valid = 4'b1000;
    do_write(1'b1);
    check("hst_awsize", 64'(cap_size), 64'd1);
    check("hst_wstrb", 64'(cap_wstrb), 64'h0C);
    check("hst_wdata", cap_wdata, 64'h1234_0000_1234_0000);
    check("hst_done", 64'(c_done), 64'b1000);
    c_valid = '0;
    @(negedge clk);
    check("hst_done_single", 64'(c_done), 64'd0);

    // Error response, then a clean read, then an id mismatch
    set_client(0, 1'b0, 32'h8000_0000, 32'h0, 4'hf);
    c_valid = 4'b0001;
    do_read(64'h0, 2'b10, 1'b0);
    check("slverr_done", 64'(c_done), 64'b0001);
    check("slverr_err", 64'(c_err), 64'b0001);
    c_valid = 4'b0010;
    do_read(64'h0000_0000_0BAD_F00D, 2'b00, 1'b0);
    check("after_err_done", 64'(c_done), 64'b0010);
    check("after_err_err", 64'(c_err), 64'd0);
    set_client(2, 1'b0, 32'h8000_0020, 32'h0, 4'hf);
    c_valid = 4'b0100;
    do_read(64'h0000_0000_1357_9BDF, 2'b00, 1'b1);
    check("bad_rid_done", 64'(c_done), 64'b0100);
    check("bad_rid_err", 64'(c_err), 64'b0100);
    check("bad_rid_rdata", 64'(c_rdata), 64'h1357_9BDF);
    c_valid = '0;
    @(negedge clk);

    // Timeout with arready never asserted
    c_valid = 4'b0100;
    wait_valid(1'b0);
    c_valid = '0;
    begin
      int n = 0;
      while (c_done == '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("tmo_cycles", 64'(n), 64'd15);
    end
    check("tmo_done", 64'(c_done), 64'b0100);
    check("tmo_err", 64'(c_err), 64'b0100);
    check("tmo_arvalid", 64'(arvalid), 64'd0);
    check("tmo_state", 64'(dbg_state), 64'(IDLE));
    check("tmo_rready", 64'(rready), 64'd1);
    rvalid = 1'b1; rid = 4'd2; rdata = 64'hFFFF_FFFF_FFFF_FFFF; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    @(negedge clk);
    check("late_beat_dropped", 64'(c_done), 64'd0);
    check("late_beat_rdata", 64'(c_rdata), 64'h1357_9BDF);

    // Asynchronous reset while in R
    set_client(1, 1'b0, 32'h8000_0030, 32'h0, 4'hf);
    c_valid = 4'b0010;
    wait_valid(1'b0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("pre_rst_state", 64'(dbg_state), 64'(R));
    #2 rst = 1'b0;
    #1;
    check("arst_state", 64'(dbg_state), 64'(IDLE));
    check("arst_rready", 64'(rready), 64'd0);
    check("arst_bready", 64'(bready), 64'd0);
    check("arst_arvalid", 64'(arvalid), 64'd0);
    check("arst_rdata", 64'(c_rdata), 64'd0);
    check("arst_done", 64'(c_done), 64'd0);
    c_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
